// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, latency and state encoding for the restoring divider
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  // start-sampling edge to the edge on which done is seen high
  localparam int DIV_LATENCY = DIV_WIDTH + 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a bit, trial subtract, keep or restore
//
// Ports:
//   rem_i  - partial remainder before the step (always < dvsr_i when dvsr_i != 0)
//   bit_i  - next dividend bit shifted into the remainder LSB
//   dvsr_i - divisor magnitude
//   rem_o  - partial remainder after the step
//   q_o    - quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;
  logic           unused_trial_msb;

  always_comb begin
    shifted          = {rem_i, bit_i};
    {borrow, trial}  = {1'b0, shifted} - {2'b00, dvsr_i};
    q_o              = ~borrow;
    // A kept trial is below the divisor and a restored value was already
    // below it, so the low WIDTH bits always hold the whole remainder.
    rem_o            = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    unused_trial_msb = trial[WIDTH];
  end

endmodule

// File: rtl/restoring_divider32.sv
// rtl/restoring_divider32.sv - fixed-latency signed/unsigned restoring divider
//
// Ports:
//   clk, rst_n          - rising-edge clock, synchronous active-low reset
//   start               - division request, only honoured in IDLE
//   is_signed           - operands are two's complement when 1
//   dividend, divisor   - operands, captured with start
//   busy                - from the cycle after start is accepted through the done cycle
//   done                - one-cycle pulse, results valid
//   quotient, remainder - results, held until overwritten by the next division
//   div_by_zero         - divisor was zero (quotient all ones, remainder = dividend)
module restoring_divider32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;       // raw dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0] b_q, b_d;       // raw divisor, replaced by its magnitude in PREP
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             dzout_q, dzout_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (quo_q[WIDTH-1]),
    .dvsr_i (b_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dzout_d = dzout_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sgn_d   = is_signed;
          a_d     = dividend;
          b_d     = divisor;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        quo_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_d     = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        rem_d   = '0;
        cnt_d   = CNT_W'(WIDTH - 1);
        negq_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        negr_d  = sgn_q & a_q[WIDTH-1];
        dz_d    = (b_q == '0);
        state_d = ST_ITER;
      end
      ST_ITER: begin
        // The quotient register doubles as the dividend shifter: its MSB
        // feeds the step while the new quotient bit enters at the LSB.
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (dz_q) begin
          qout_d  = '1;
          rout_d  = a_q;
          dzout_d = 1'b1;
        end else begin
          // -2^(W-1) / -1 lands here with equal signs, leaving 0x80..0 unchanged.
          qout_d  = negq_q ? -quo_q : quo_q;
          rout_d  = negr_q ? -rem_q : rem_q;
          dzout_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      dzout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dzout_q <= dzout_d;
    end
  end

  assign quotient    = qout_q;
  assign remainder   = rout_q;
  assign div_by_zero = dzout_q;

endmodule
